lut_reg_deser6: RTL

- Serial-to-parallel counterpart of the LUT/register AND-reduce benchmark.
- The existing benchmark registers six inputs, reduces them through a LUT and double-registers one output.
- This block does the opposite: it takes one registered serial bit stream, assembles WIDTH-bit words, and drives the word plus LUT-derived flags through registered pipeline stages.
- It is a CLB benchmark that exercises shift registers, counters, a LUT level and FF chains with reset.

---
 rtl/lut_reg_pkg.sv | 33 +++
 rtl/lut_reg_reduce_stage.sv | 44 ++++
 rtl/lut_reg_deser6.sv | 119 +++++++++++
 3 files changed

// File: rtl/lut_reg_pkg.sv
// Shared constants and reduce helper for the LUT/register deserializer.
// Flags are computed over the low n bits of a zero-extended word.
package lut_reg_pkg;

   localparam int DESER_WIDTH = 6;
   localparam int DESER_CNT_W = 8;
   localparam int DESER_MAX_W = 16;

   typedef struct packed {
      logic a;
      logic o;
      logic p;
   } flags_t;

   function automatic flags_t reduce_flags(
      input logic [DESER_MAX_W-1:0] w,
      input int                     n
   );
      flags_t f;
      f.a = 1'b1;
      f.o = 1'b0;
      f.p = 1'b0;
      for (int i = 0; i < DESER_MAX_W; i++) begin
         if (i < n) begin
            f.a = f.a & w[i];
            f.o = f.o | w[i];
            f.p = f.p ^ w[i];
         end
      end
      return f;
   endfunction

endpackage

// File: rtl/lut_reg_reduce_stage.sv
// Registered AND/OR/XOR reduce of one word with valid passthrough.
// Word and flags hold between strobes; valid follows input every cycle.
module lut_reg_reduce_stage
   import lut_reg_pkg::*;
#(
   parameter int WIDTH = DESER_WIDTH
) (
   input  logic             clock0,
   input  logic             reset0_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_word,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_word,
   output logic             out_and,
   output logic             out_or,
   output logic             out_par
);

   logic [DESER_MAX_W-1:0] ext;
   flags_t                 fl;

   assign ext = DESER_MAX_W'(in_word);
   assign fl  = reduce_flags(ext, WIDTH);

   // capture word and its flags on each strobe
   always_ff @(posedge clock0 or negedge reset0_n) begin
      if (!reset0_n) begin
         out_valid <= 1'b0;
         out_word  <= '0;
         out_and   <= 1'b0;
         out_or    <= 1'b0;
         out_par   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_word <= in_word;
            out_and  <= fl.a;
            out_or   <= fl.o;
            out_par  <= fl.p;
         end
      end
   end

endmodule

// File: rtl/lut_reg_deser6.sv
// Serial-to-parallel word assembler with LUT-derived flags.
// Input regs, assembly, reduce stage and output regs form the pipeline.
module lut_reg_deser6
   import lut_reg_pkg::*;
#(
   parameter int WIDTH = DESER_WIDTH,
   parameter int CNT_W = DESER_CNT_W
) (
   input  logic             clock0,
   input  logic             reset0_n,
   input  logic             serial_in,
   input  logic             serial_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             and_flag,
   output logic             or_flag,
   output logic             parity_flag,
   output logic             frame_err,
   output logic [CNT_W-1:0] word_count
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

   logic             in_d;
   logic             vld_d;
   logic             fs_d;
   logic [WIDTH-2:0] shift_q;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] word_q;
   logic             wstb;
   logic [WIDTH-1:0] cat;
   logic             v2;
   logic [WIDTH-1:0] word2;
   logic             and2;
   logic             or2;
   logic             par2;

   // low WIDTH-1 bits of this are the shifted-in partial word
   assign cat = {shift_q, in_d};

   // register the raw serial pins
   always_ff @(posedge clock0 or negedge reset0_n) begin
      if (!reset0_n) begin
         in_d  <= 1'b0;
         vld_d <= 1'b0;
         fs_d  <= 1'b0;
      end else begin
         in_d  <= serial_in;
         vld_d <= serial_valid;
         fs_d  <= frame_start;
      end
   end

   // shift bits in; frame_start realigns, completion emits a word
   always_ff @(posedge clock0 or negedge reset0_n) begin
      if (!reset0_n) begin
         shift_q   <= '0;
         bit_cnt   <= '0;
         word_q    <= '0;
         wstb      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         wstb <= 1'b0;
         if (vld_d) begin
            if (fs_d) begin
               shift_q    <= '0;
               shift_q[0] <= in_d;
               bit_cnt    <= BW'(1);
               if (bit_cnt != '0) frame_err <= 1'b1;
            end else if (bit_cnt != LAST) begin
               shift_q <= cat[WIDTH-2:0];
               bit_cnt <= bit_cnt + BW'(1);
            end else begin
               word_q  <= cat;
               wstb    <= 1'b1;
               bit_cnt <= '0;
            end
         end
      end
   end

   lut_reg_reduce_stage #(
      .WIDTH(WIDTH)
   ) u_reduce (
      .clock0   (clock0),
      .reset0_n (reset0_n),
      .in_valid (wstb),
      .in_word  (word_q),
      .out_valid(v2),
      .out_word (word2),
      .out_and  (and2),
      .out_or   (or2),
      .out_par  (par2)
   );

   // output registers and completed-word counter
   always_ff @(posedge clock0 or negedge reset0_n) begin
      if (!reset0_n) begin
         data_out    <= '0;
         data_valid  <= 1'b0;
         and_flag    <= 1'b0;
         or_flag     <= 1'b0;
         parity_flag <= 1'b0;
         word_count  <= '0;
      end else begin
         data_valid <= v2;
         if (v2) begin
            data_out    <= word2;
            and_flag    <= and2;
            or_flag     <= or2;
            parity_flag <= par2;
            word_count  <= word_count + CNT_W'(1);
         end
      end
   end

endmodule
